alu_issue: RTL and testbench
============================

# alu_issue

Execute-stage issue register that sits directly upstream of the ALU. Accepts a decoded-stage bundle (instruction word plus the two register-file read values), derives the ALU's 4-bit operation select and the X/Y operands, and holds them in a registered valid/ready stage with a one-entry skid buffer. Downstream backpressure (ALU/writeback stall) never drops or corrupts an issued operation.

## Interface
Parameters:
- none; all widths fixed: 32-bit data, 4-bit select, 5-bit register index.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous flush; discards all held entries.
- in_valid  in  1  upstream bundle valid.
- in_ready  out  1  stage can accept; equals NOT skid_valid.
- instr  in  32  instruction word (opcode [31:26], rt [20:16], rd [15:11], funct [5:0], imm [15:0]).
- rs_data  in  32  register-file value for rs.
- rt_data  in  32  register-file value for rt.
- out_valid  out  1  ALU bundle valid.
- out_ready  in  1  downstream consumes the bundle this cycle.
- X  out  32  ALU operand A.
- Y  out  32  ALU operand B.
- S  out  4  ALU select.
- dst  out  5  destination register index.
- illegal  out  1  unsupported instruction.

## Operation
- Decode is combinational on the inputs and registered at acceptance (in_valid && in_ready).
- R-type (opcode 0): X=rs_data, Y=rt_data, dst=rd; funct 0x24 AND→S=0; 0x25 OR→1; 0x20/0x21 ADD/ADDU→2; 0x22/0x23 SUB/SUBU→6; 0x2A SLT→7; 0x27 NOR→12.
- Any other funct or opcode: S=2, X=rs_data, Y=rt_data, dst=0, illegal=1; bundle still flows through the handshake.
- Storage: main register (drives outputs) plus skid register. States: EMPTY (neither valid), ONE (main valid), TWO (main and skid valid).
- EMPTY: accept→ONE.
- ONE: accept and out_ready→ONE (main reloaded); accept and not out_ready→TWO (new entry into skid); out_ready, no accept→EMPTY.
- TWO: in_ready=0; out_ready→ONE with skid copied into main; otherwise hold.
- Outputs X/Y/S/dst/illegal stable whenever out_valid && !out_ready.
- flush: next state EMPTY regardless of other inputs; a bundle offered the same cycle is dropped. Flush has priority over acceptance and transfer.

## Timing
- Reset (async assert): out_valid=0, in_ready=1, X=0, Y=0, S=0, dst=0, illegal=0, skid cleared.
- Latency: accepted bundle on out_valid the next cycle.
- Throughput: one bundle/cycle while out_ready held high.
- in_ready is registered-derived (no combinational path from out_ready).
- Reset release mid-stream: no bundle survives; first accept possible the first edge after deassertion.

## Configuration
- ALU_ISSUE_IMM_EN defined: I-type supported, X=rs_data, dst=instr[20:16]: opcode 0x08 ADDI→S=2, Y=sign-extended imm; 0x0C ANDI→S=0, Y=zero-extended imm; 0x0D ORI→S=1, Y=zero-extended imm; 0x0A SLTI→S=7, Y=sign-extended imm.
- Undefined: those opcodes take the illegal path (S=2, illegal=1, dst=0).

## Test plan
- Reset: hold rst_n=0 mid-traffic → out_valid=0, in_ready=1, all data outputs 0 immediately.
- Streaming: out_ready=1, issue SUB rs=0x10, rt=0x3 → next cycle out_valid=1, S=6, X=0x10, Y=0x3, dst=rd; six R-type ops back-to-back emerge one per cycle in order.
- Backpressure: out_ready=0, issue AND then NOR → in_ready drops to 0 after second accept; outputs hold AND (S=0); raise out_ready → NOR (S=12) appears next, no loss or duplication.
- Illegal: funct 0x18 → illegal=1, S=2, dst=0, transfers normally.
- Flush: state TWO with in_valid=1 and flush=1 → next cycle out_valid=0, in_ready=1; offered bundle never appears.
- Immediate (with ALU_ISSUE_IMM_EN): ADDI imm=0xFFFF → Y=0xFFFFFFFF, S=2; ORI imm=0xFFFF → Y=0x0000FFFF, S=1; without macro both → illegal=1.

Source files
------------

// File: rtl/alu_issue.sv
// alu_issue: decodes an instruction into ALU select/operands and holds the result
// in a valid/ready issue register with a one-entry skid buffer. I-type: ALU_ISSUE_IMM_EN.
// Ports: clk, rst_n, flush | in_valid/in_ready, instr, rs_data, rt_data
//        | out_valid/out_ready, X, Y, S, dst, illegal
module alu_issue (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] X,
  output logic [31:0] Y,
  output logic [3:0]  S,
  output logic [4:0]  dst,
  output logic        illegal
);

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [3:0]  s;
    logic [4:0]  dst;
    logic        ill;
  } issue_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t st;
  issue_t main_q;
  issue_t skid_q;
  issue_t dec;

  logic [5:0] opc;
  logic [5:0] fn;
  logic       acc;
  logic       unused;

  assign opc = instr[31:26];
  assign fn  = instr[5:0];
  assign unused = ^{instr[25:16], instr[10:6]};

  always_comb begin
    dec     = '0;
    dec.x   = rs_data;
    dec.y   = rt_data;
    dec.s   = 4'd2;
    dec.dst = 5'd0;
    dec.ill = 1'b1;
    if (opc == 6'h00) begin
      unique case (fn)
        6'h24: begin
          dec.s = 4'd0; dec.ill = 1'b0;
        end
        6'h25: begin
          dec.s = 4'd1; dec.ill = 1'b0;
        end
        6'h20, 6'h21: begin
          dec.s = 4'd2; dec.ill = 1'b0;
        end
        6'h22, 6'h23: begin
          dec.s = 4'd6; dec.ill = 1'b0;
        end
        6'h2A: begin
          dec.s = 4'd7; dec.ill = 1'b0;
        end
        6'h27: begin
          dec.s = 4'd12; dec.ill = 1'b0;
        end
        default: dec.ill = 1'b1;
      endcase
      if (!dec.ill)
        dec.dst = instr[15:11];
    end
`ifdef ALU_ISSUE_IMM_EN
    else begin
      unique case (opc)
        6'h08: begin
          dec.s = 4'd2; dec.ill = 1'b0;
          dec.y = {{16{instr[15]}}, instr[15:0]};
        end
        6'h0C: begin
          dec.s = 4'd0; dec.ill = 1'b0;
          dec.y = {16'h0, instr[15:0]};
        end
        6'h0D: begin
          dec.s = 4'd1; dec.ill = 1'b0;
          dec.y = {16'h0, instr[15:0]};
        end
        6'h0A: begin
          dec.s = 4'd7; dec.ill = 1'b0;
          dec.y = {{16{instr[15]}}, instr[15:0]};
        end
        default: dec.ill = 1'b1;
      endcase
      if (!dec.ill)
        dec.dst = instr[20:16];
    end
`endif
  end

  // Both handshake outputs come straight from the state register.
  assign in_ready  = (st != TWO);
  assign out_valid = (st != EMPTY);
  assign acc       = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st     <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      st <= EMPTY;
    end else begin
      unique case (st)
        EMPTY: begin
          if (acc) begin
            main_q <= dec;
            st     <= ONE;
          end
        end
        ONE: begin
          if (acc && out_ready) begin
            main_q <= dec;
          end else if (acc) begin
            skid_q <= dec;
            st     <= TWO;
          end else if (out_ready) begin
            st <= EMPTY;
          end
        end
        TWO: begin
          if (out_ready) begin
            main_q <= skid_q;
            st     <= ONE;
          end
        end
        default: st <= EMPTY;
      endcase
    end
  end

  assign X       = main_q.x;
  assign Y       = main_q.y;
  assign S       = main_q.s;
  assign dst     = main_q.dst;
  assign illegal = main_q.ill;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed and random stimulus against a queue-based model
// of the issue stage; prints one TB_RESULT summary line.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] X;
  logic [31:0] Y;
  logic [3:0]  S;
  logic [4:0]  dst;
  logic        illegal;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [3:0]  s;
    logic [4:0]  d;
    logic        il;
  } exp_t;

  exp_t q[$];

  alu_issue dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .X(X), .Y(Y), .S(S), .dst(dst), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t ref_dec(input logic [31:0] ins,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
    exp_t e;
    int sel;
    sel = -1;
    e.x = a; e.y = b; e.s = 4'd2; e.d = 5'd0; e.il = 1'b1;
    if (ins[31:26] == 6'h00) begin
      case (ins[5:0])
        6'h24: sel = 0;
        6'h25: sel = 1;
        6'h20, 6'h21: sel = 2;
        6'h22, 6'h23: sel = 6;
        6'h2A: sel = 7;
        6'h27: sel = 12;
        default: sel = -1;
      endcase
      if (sel >= 0) begin
        e.s = 4'(sel); e.d = ins[15:11]; e.il = 1'b0;
      end
    end
`ifdef ALU_ISSUE_IMM_EN
    else begin
      int sx;
      sx = int'($signed(ins[15:0]));
      case (ins[31:26])
        6'h08: begin sel = 2; e.y = 32'(sx); end
        6'h0C: begin sel = 0; e.y = 32'(ins[15:0]); end
        6'h0D: begin sel = 1; e.y = 32'(ins[15:0]); end
        6'h0A: begin sel = 7; e.y = 32'(sx); end
        default: sel = -1;
      endcase
      if (sel >= 0) begin
        e.s = 4'(sel); e.d = ins[20:16]; e.il = 1'b0;
      end
    end
`endif
    return e;
  endfunction

  function automatic logic [31:0] mk_r(input logic [5:0] fn,
                                       input logic [4:0] rd);
    logic [31:0] w;
    w = $urandom;
    w[31:26] = 6'h00;
    w[15:11] = rd;
    w[5:0] = fn;
    return w;
  endfunction

  function automatic logic [31:0] mk_i(input logic [5:0] op,
                                       input logic [15:0] imm);
    logic [31:0] w;
    w = $urandom;
    w[31:26] = op;
    w[15:0] = imm;
    return w;
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [5:0] fns [9];
    logic [5:0] ops [4];
    fns = '{6'h24, 6'h25, 6'h20, 6'h21, 6'h22, 6'h23, 6'h2A, 6'h27, 6'h18};
    ops = '{6'h08, 6'h0C, 6'h0D, 6'h0A};
    case ($urandom_range(0, 9))
      0, 1: return mk_i(ops[$urandom_range(0, 3)], 16'($urandom));
      2: return $urandom;
      default: return mk_r(fns[$urandom_range(0, 8)], 5'($urandom));
    endcase
  endfunction

  task automatic compare(input string tag);
    chk({tag, ".ov"}, 32'(out_valid), 32'(q.size() > 0));
    chk({tag, ".ir"}, 32'(in_ready), 32'(q.size() < 2));
    if (q.size() > 0) begin
      chk({tag, ".X"}, X, q[0].x);
      chk({tag, ".Y"}, Y, q[0].y);
      chk({tag, ".S"}, 32'(S), 32'(q[0].s));
      chk({tag, ".dst"}, 32'(dst), 32'(q[0].d));
      chk({tag, ".ill"}, 32'(illegal), 32'(q[0].il));
    end
  endtask

  task automatic cyc(input string tag, input logic v,
                     input logic [31:0] ins, input logic [31:0] a,
                     input logic [31:0] b, input logic ordy,
                     input logic fl);
    bit acc;
    in_valid = v; instr = ins; rs_data = a; rt_data = b;
    out_ready = ordy; flush = fl;
    acc = v && (q.size() < 2);
    if (fl) q.delete();
    else begin
      if (ordy && q.size() > 0) void'(q.pop_front());
      if (acc) q.push_back(ref_dec(ins, a, b));
    end
    @(posedge clk);
    @(negedge clk);
    compare(tag);
  endtask

  task automatic idle(input logic ordy);
    cyc("idle", 1'b0, 32'h0, 32'h0, 32'h0, ordy, 1'b0);
  endtask

  task automatic reset_now(input string tag);
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    chk({tag, ".ov"}, 32'(out_valid), 32'd0);
    chk({tag, ".ir"}, 32'(in_ready), 32'd1);
    chk({tag, ".X"}, X, 32'd0);
    chk({tag, ".Y"}, Y, 32'd0);
    chk({tag, ".S"}, 32'(S), 32'd0);
    chk({tag, ".dst"}, 32'(dst), 32'd0);
    chk({tag, ".ill"}, 32'(illegal), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instr = '0; rs_data = '0; rt_data = '0;
    @(negedge clk);
    reset_now("rst0");

    // Streaming: SUB then six R-type ops back to back.
    cyc("sub", 1'b1, mk_r(6'h22, 5'd5), 32'h10, 32'h3, 1'b1, 1'b0);
    chk("sub.S", 32'(S), 32'd6);
    chk("sub.X", X, 32'h10);
    chk("sub.Y", Y, 32'h3);
    chk("sub.dst", 32'(dst), 32'd5);
    for (int i = 0; i < 6; i++) begin
      logic [5:0] f6 [6];
      f6 = '{6'h24, 6'h25, 6'h20, 6'h23, 6'h2A, 6'h27};
      cyc("strm", 1'b1, mk_r(f6[i], 5'(i + 1)), $urandom, $urandom,
          1'b1, 1'b0);
      chk("strm.dst", 32'(dst), 32'(i + 1));
    end
    idle(1'b1);
    chk("drain.ov", 32'(out_valid), 32'd0);

    // Backpressure: AND then NOR with out_ready low.
    cyc("and", 1'b1, mk_r(6'h24, 5'd7), 32'hF0F0, 32'h0FF0, 1'b0, 1'b0);
    cyc("nor", 1'b1, mk_r(6'h27, 5'd8), 32'h1, 32'h2, 1'b0, 1'b0);
    chk("bp.ir", 32'(in_ready), 32'd0);
    chk("bp.S", 32'(S), 32'd0);
    cyc("bp.blk", 1'b1, mk_r(6'h20, 5'd9), 32'h5, 32'h6, 1'b0, 1'b0);
    chk("bp.hold", 32'(S), 32'd0);
    idle(1'b1);
    chk("bp.nor", 32'(S), 32'd12);
    chk("bp.nordst", 32'(dst), 32'd8);
    idle(1'b1);
    chk("bp.empty", 32'(out_valid), 32'd0);

    // Illegal funct.
    cyc("ill", 1'b1, mk_r(6'h18, 5'd9), 32'hA, 32'hB, 1'b1, 1'b0);
    chk("ill.il", 32'(illegal), 32'd1);
    chk("ill.S", 32'(S), 32'd2);
    chk("ill.dst", 32'(dst), 32'd0);
    idle(1'b1);

    // Flush from TWO with a bundle on offer.
    cyc("f1", 1'b1, mk_r(6'h20, 5'd1), 32'h1, 32'h1, 1'b0, 1'b0);
    cyc("f2", 1'b1, mk_r(6'h25, 5'd2), 32'h2, 32'h2, 1'b0, 1'b0);
    cyc("fl", 1'b1, mk_r(6'h22, 5'd3), 32'h3, 32'h3, 1'b1, 1'b1);
    chk("fl.ov", 32'(out_valid), 32'd0);
    chk("fl.ir", 32'(in_ready), 32'd1);
    idle(1'b1);
    chk("fl.gone", 32'(out_valid), 32'd0);

    // Immediate forms.
    cyc("addi", 1'b1, mk_i(6'h08, 16'hFFFF), 32'h7, 32'h9, 1'b1, 1'b0);
`ifdef ALU_ISSUE_IMM_EN
    chk("addi.Y", Y, 32'hFFFFFFFF);
    chk("addi.S", 32'(S), 32'd2);
`else
    chk("addi.il", 32'(illegal), 32'd1);
`endif
    cyc("ori", 1'b1, mk_i(6'h0D, 16'hFFFF), 32'h7, 32'h9, 1'b1, 1'b0);
`ifdef ALU_ISSUE_IMM_EN
    chk("ori.Y", Y, 32'h0000FFFF);
    chk("ori.S", 32'(S), 32'd1);
`else
    chk("ori.il", 32'(illegal), 32'd1);
`endif
    idle(1'b1);

    // Random traffic with a mid-stream reset.
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) begin
        cyc("pre", 1'b1, rnd_instr(), $urandom, $urandom, 1'b0, 1'b0);
        reset_now("rstm");
        cyc("post", 1'b1, mk_r(6'h21, 5'd4), 32'h11, 32'h22, 1'b0, 1'b0);
        chk("post.ov", 32'(out_valid), 32'd1);
      end
      cyc("rnd", 1'($urandom_range(0, 3) != 0), rnd_instr(), $urandom,
          $urandom, 1'($urandom_range(0, 2) != 0),
          1'($urandom_range(0, 40) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
